// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the instruction-fetch stage's bus signals: the hazard, decode and
//   CP0 controls coming in, the combinational instruction-memory port, and
//   the IF/ID register outputs going to decode.
//   master : the fetch stage (drives pc_F, imem_addr and the *_D outputs)
//   slave  : the surrounding pipeline / memory (drives controls, imem_rdata)
interface fetch_stage_if;
    logic        stall;
    logic        PCSrc;
    logic [31:0] NPC_D;
    logic        BJ_D;
    logic        eret_d;
    logic [31:0] EPC;
    logic        exc_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic [31:0] PC8_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D;

    modport master (
        input  stall, PCSrc, NPC_D, BJ_D, eret_d, EPC, exc_req, imem_rdata,
        output imem_addr, pc_F, Instr_D, PC_D, PC4_D, PC8_D, ExcCode_D, BD_D
    );

    modport slave (
        output stall, PCSrc, NPC_D, BJ_D, eret_d, EPC, exc_req, imem_rdata,
        input  imem_addr, pc_F, Instr_D, PC_D, PC4_D, PC8_D, ExcCode_D, BD_D
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage plus IF/ID pipeline register of a 5-stage MIPS pipeline.
//   Holds the fetch PC, presents it to the combinational instruction memory
//   and selects the next PC (sequential, branch/jump, eret, exception entry).
//   Registers the fetched instruction and its PC/PC+4/PC+8 for decode, with
//   stall, flush, delay-slot tagging and optional fetch address-error tagging.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : fetch_stage_if.master
//            in : stall, PCSrc, NPC_D, BJ_D, eret_d, EPC, exc_req, imem_rdata
//            out: imem_addr, pc_F, Instr_D, PC_D, PC4_D, PC8_D, ExcCode_D, BD_D
//
// Build option:
//   ADDR_CHECK_EN : when defined, fetches that are misaligned or outside
//                   [IM_LO, IM_HI] enter decode as a nop tagged ExcCode 4
//                   (AdEL). When undefined, ExcCode_D stays 0.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
`ifdef ADDR_CHECK_EN
    ,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
`endif
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        addr_err;

    assign pc_plus4      = bus.pc_F + 32'd4;
    assign pc_plus8      = bus.pc_F + 32'd8;
    assign bus.imem_addr = bus.pc_F;

`ifdef ADDR_CHECK_EN
    assign addr_err = (bus.pc_F[1:0] != 2'b00) || (bus.pc_F < IM_LO) || (bus.pc_F > IM_HI);
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc_F      <= PC_RESET;
            bus.Instr_D   <= 32'd0;
            bus.PC_D      <= PC_RESET;
            bus.PC4_D     <= PC_RESET + 32'd4;
            bus.PC8_D     <= PC_RESET + 32'd8;
            bus.ExcCode_D <= EXC_NONE;
            bus.BD_D      <= 1'b0;
        end else if (bus.exc_req) begin
            // Exception entry beats stall: the handler must start even if
            // the hazard unit is holding the front end.
            bus.pc_F      <= EXC_ENTRY;
            bus.Instr_D   <= 32'd0;
            bus.PC_D      <= bus.pc_F;
            bus.PC4_D     <= pc_plus4;
            bus.PC8_D     <= pc_plus8;
            bus.ExcCode_D <= EXC_NONE;
            bus.BD_D      <= 1'b0;
        end else if (bus.stall) begin
            // hold everything; decode re-presents eret/branch next cycle
        end else if (bus.eret_d) begin
            // eret has no delay slot, so the word fetched behind it is dropped
            bus.pc_F      <= bus.EPC;
            bus.Instr_D   <= 32'd0;
            bus.PC_D      <= bus.pc_F;
            bus.PC4_D     <= pc_plus4;
            bus.PC8_D     <= pc_plus8;
            bus.ExcCode_D <= EXC_NONE;
            bus.BD_D      <= 1'b0;
        end else begin
            bus.pc_F      <= bus.PCSrc ? bus.NPC_D : pc_plus4;
            bus.Instr_D   <= addr_err ? 32'd0 : bus.imem_rdata;
            bus.PC_D      <= bus.pc_F;
            bus.PC4_D     <= pc_plus4;
            bus.PC8_D     <= pc_plus8;
            bus.ExcCode_D <= addr_err ? EXC_ADEL : EXC_NONE;
            // the delay-slot word enters D whether or not the branch is taken
            bus.BD_D      <= bus.BJ_D;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the decode stage.
- Holds the PC, drives the combinational instruction-memory read and selects the next PC from sequential, branch/jump, eret and exception-entry sources.
- Registers Instr_D, PC4_D and PC8_D for decode, with stall, flush, delay-slot tagging and fetch address-error detection.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry address
IM_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
PCSrc  in  1  decode: taken branch/jump in D
NPC_D  in  32  decode: branch/jump target
BJ_D  in  1  decode: instruction in D is a branch/jump, taken or not
eret_d  in  1  decode: eret in D
EPC  in  32  CP0 EPC value
exc_req  in  1  CP0: exception/interrupt taken this cycle
imem_addr  out  32  instruction memory address (= pc_F)
imem_rdata  in  32  instruction memory data, combinational
pc_F  out  32  current fetch PC
Instr_D  out  32  registered instruction for decode
PC_D  out  32  registered PC of Instr_D
PC4_D  out  32  PC_D+4
PC8_D  out  32  PC_D+8
ExcCode_D  out  5  registered fetch exception code (0 none, 4 AdEL)
BD_D  out  1  Instr_D is in a branch delay slot

Behaviour:
- Clock is clk. Reset is synchronous and active-high on the reset port.
- Reset values: pc_F=PC_RESET; Instr_D=0; PC_D=PC_RESET; PC4_D=PC_RESET+4; PC8_D=PC_RESET+8; ExcCode_D=0; BD_D=0.
- imem_addr=pc_F. Instr_D, PC_D, PC4_D, PC8_D, ExcCode_D and BD_D appear one cycle after pc_F is presented.
- Per-edge priority for PC and IF/ID: reset > exc_req > stall > eret_d > normal.
- exc_req:
  - pc_F<=EXC_ENTRY.
  - IF/ID flushed: Instr_D<=0, ExcCode_D<=0, BD_D<=0; PC_D<=pc_F, PC4/PC8 follow PC_D.
  - Overrides stall.
- stall (no exc_req): all registers hold. eret_d and PCSrc are ignored that cycle; decode re-presents them next cycle.
- eret_d (no stall):
  - pc_F<=EPC.
  - IF/ID flushed as above. eret has no delay slot; the instruction fetched behind it is discarded.
- Normal cycle:
  - pc_F<=PCSrc ? NPC_D : pc_F+4.
  - Instr_D<=fetched instruction; PC_D<=pc_F; PC4_D<=pc_F+4; PC8_D<=pc_F+8; BD_D<=BJ_D.
  - The delay-slot instruction always enters D, whether the branch is taken or not.
- Address error (feature on): fetch is illegal if pc_F[1:0]!=0, pc_F<IM_LO or pc_F>IM_HI.
  - Instr_D<=0 (nop), ExcCode_D<=4; PC_D still latches the faulting pc_F.
  - PC advancement is unaffected. CP0 raises exc_req when the tagged nop reaches M.
- All additions are 32-bit unsigned and wrap modulo 2^32. No overflow flag.
- Simultaneous PCSrc and eret_d cannot occur; eret_d wins if asserted.

Optional Feature:
ADDR_CHECK_EN
- Defined: alignment/range check active; AdEL tagging as in Behaviour.
- Undefined: no check; ExcCode_D is constant 0; Instr_D is always imem_rdata.

Test Plan:
1. Reset 2 cycles, then release; imem returns 32'h2408_0001 -> pc_F=0x3000 during reset; next edge Instr_D=32'h2408_0001, PC_D=0x3000, PC4_D=0x3004, PC8_D=0x3008, pc_F=0x3004.
2. Branch at 0x3008 in D with PCSrc=1, NPC_D=0x3020, BJ_D=1 -> delay slot 0x300C enters D with BD_D=1; following fetch pc_F=0x3020, BD_D=0 after.
3. stall=1 for 3 cycles at pc_F=0x3010 -> pc_F, Instr_D, PC_D unchanged; releases and resumes 0x3014; PCSrc during stall is ignored.
4. exc_req=1 together with stall=1 at pc_F=0x3040 -> pc_F=0x4180, Instr_D=0, BD_D=0, ExcCode_D=0.
5. eret_d=1, EPC=0x3058 -> pc_F=0x3058 next edge, Instr_D=0; eret_d with stall=1 -> no change.
6. ADDR_CHECK_EN defined, NPC_D=0x3002 taken -> Instr_D=0, ExcCode_D=4, PC_D=0x3002; NPC_D=0x7000 -> ExcCode_D=4. Macro undefined -> ExcCode_D=0.
